// File: rtl/counter_nch.sv
// rtl/counter_nch.sv - multi-channel programmable timer/counter with prescaler and sticky interrupts
//
// Purpose: CH_NUM independent timer channels, each with a reload value, a
// down/up counter, a prescaler and four modes (one-shot, periodic, square
// wave, free-run up). Registers are written through a simple strobe port;
// the count of the addressed channel is read back with one cycle latency.
//
// Ports:
//   clk       - sole clock, all state updates on the rising edge
//   RSTN      - synchronous active-low reset
//   we        - register write strobe (one write per asserted cycle)
//   addr      - {channel, reg}; reg 0=LOAD, 1=CTRL, 2=IRQ_CLR, 3=reserved
//   wdata     - write data
//   rd_data   - registered count of the channel selected by addr
//   ch_out    - per-channel event/level output
//   irq_pend  - sticky per-channel pending flags
//   irq       - OR of pending flags gated by per-channel irq enables

module counter_nch #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic                      clk,
  input  logic                      RSTN,
  input  logic                      we,
  input  logic [$clog2(CH_NUM)+1:0] addr,
  input  logic [CNT_W-1:0]          wdata,
  output logic [CNT_W-1:0]          rd_data,
  output logic [CH_NUM-1:0]         ch_out,
  output logic [CH_NUM-1:0]         irq_pend,
  output logic                      irq
);

  // Channel-index width; at least one bit so a single-channel build still
  // has a legal select signal.
  localparam int CIW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  // CTRL fields reach up to bit 8+PRE_W-1, which may lie above CNT_W.
  localparam int CTW = 8 + PRE_W;
  localparam int XW  = (CNT_W > CTW) ? CNT_W : CTW;

  localparam logic [1:0] REG_LOAD = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_CLR  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_SQUARE   = 2'd2;
  localparam logic [1:0] MODE_FREE     = 2'd3;

  logic [1:0]     sel_reg;
  logic [CIW-1:0] sel_ch;
  logic           sel_valid;
  logic [XW-1:0]  wdata_x;
  logic           unused_bits;

  always_comb begin
    sel_reg   = addr[1:0];
    sel_ch    = CIW'(addr >> 2);
    sel_valid = (32'(sel_ch) < 32'(CH_NUM));
    wdata_x   = XW'(wdata);
  end

  // Several wdata bits have no register behind them.
  assign unused_bits = ^wdata_x;

  // Padded to a power of two so any channel index is a legal array index;
  // the padding entries read as zero.
  logic [CNT_W-1:0]  count_all [2**CIW];
  logic [CH_NUM-1:0] irq_en_v;

  for (genvar j = CH_NUM; j < 2**CIW; j++) begin : g_pad
    assign count_all[j] = '0;
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] count_q;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [1:0]       mode_q;
    logic             en_q;
    logic             irq_en_q;
    logic             pend_q;
    logic             out_q;

    logic             hit;
    logic             wr_load;
    logic             wr_ctrl;
    logic             wr_clr;
    logic             tick;
    logic             evt;
    logic [CNT_W-1:0] count_d;
    logic             out_d;

    always_comb begin
      hit     = we && sel_valid && (sel_ch == CIW'(i));
      wr_load = hit && (sel_reg == REG_LOAD);
      wr_ctrl = hit && (sel_reg == REG_CTRL);
      wr_clr  = hit && (sel_reg == REG_CLR);
      // A LOAD or CTRL write swallows a coinciding tick; IRQ_CLR does not,
      // so a reload event in the same cycle still sets pend.
      tick    = en_q && (pre_cnt_q == presc_q) && !(wr_load || wr_ctrl);
      evt     = 1'b0;
      count_d = count_q;
      out_d   = out_q;
      case (mode_q)
        MODE_ONESHOT: begin
          if (tick && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              evt   = 1'b1;
              out_d = 1'b1;
            end
          end
        end
        MODE_PERIODIC, MODE_SQUARE: begin
          if (mode_q == MODE_PERIODIC) begin
            out_d = 1'b0;
          end
          if (tick) begin
            if (count_q == '0) begin
              count_d = load_q;
              evt     = 1'b1;
              out_d   = (mode_q == MODE_PERIODIC) ? 1'b1 : ~out_q;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        default: begin
          out_d = 1'b0;
          if (tick) begin
            count_d = count_q + CNT_W'(1);
            if (count_q == '1) begin
              evt   = 1'b1;
              out_d = 1'b1;
            end
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!RSTN) begin
        load_q    <= '0;
        count_q   <= '0;
        presc_q   <= '0;
        pre_cnt_q <= '0;
        mode_q    <= MODE_ONESHOT;
        en_q      <= 1'b0;
        irq_en_q  <= 1'b0;
        pend_q    <= 1'b0;
        out_q     <= 1'b0;
      end else begin
        if (wr_load) begin
          load_q    <= wdata;
          count_q   <= wdata;
          pre_cnt_q <= '0;
          // Square-wave phase survives a reload value change.
          if (mode_q != MODE_SQUARE) begin
            out_q <= 1'b0;
          end
        end else if (wr_ctrl) begin
          en_q      <= wdata[0];
          mode_q    <= wdata[2:1];
          irq_en_q  <= wdata[3];
          presc_q   <= wdata_x[CTW-1:8];
          pre_cnt_q <= '0;
          // Entering a pulse mode must not leave a stale level high.
          if ((wdata[2:1] == MODE_PERIODIC) || (wdata[2:1] == MODE_FREE)) begin
            out_q <= 1'b0;
          end
        end else begin
          count_q <= count_d;
          out_q   <= out_d;
          if (en_q) begin
            pre_cnt_q <= tick ? '0 : pre_cnt_q + PRE_W'(1);
          end
        end

        if (evt) begin
          pend_q <= 1'b1;
        end else if (wr_clr) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign count_all[i] = count_q;
    assign ch_out[i]    = out_q;
    assign irq_pend[i]  = pend_q;
    assign irq_en_v[i]  = irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      rd_data <= '0;
    end else begin
      rd_data <= sel_valid ? count_all[sel_ch] : '0;
    end
  end

  assign irq = |(irq_pend & irq_en_v);

endmodule

// File: doc/counter_nch.md
COUNTER_NCH -- requirements
Module: counter_nch

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter and reload width in bits (8..32).
REQ-003 SHALL have parameter PRE_W, default 8, prescaler width in bits.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port RSTN, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port we, input, 1, register write strobe, one write per asserted cycle.
REQ-007 SHALL have port addr, input, $clog2(CH_NUM)+2, {channel, reg}; reg 0=LOAD, 1=CTRL, 2=IRQ_CLR, 3=reserved.
REQ-008 SHALL have port wdata, input, CNT_W, write data.
REQ-009 SHALL have port rd_data, output, CNT_W, count of the channel in addr[high bits], registered.
REQ-010 SHALL have port ch_out, output, CH_NUM, per-channel event/level output.
REQ-011 SHALL have port irq_pend, output, CH_NUM, sticky per-channel pending flags.
REQ-012 SHALL have port irq, output, 1, OR of (irq_pend AND per-channel irq_en).

Function
REQ-013 SHALL hold per channel: load[CNT_W], count[CNT_W], en, mode[1:0], irq_en, presc[PRE_W], pre_cnt[PRE_W], pend, out.
REQ-014 SHALL on write LOAD: load<=wdata, count<=wdata, pre_cnt<=0, out<=0 (mode 0/1/3), next cycle visible.
REQ-015 SHALL on write CTRL: en<=wdata[0], mode<=wdata[2:1], irq_en<=wdata[3], presc<=wdata[8+PRE_W-1:8], pre_cnt<=0; count unchanged.
REQ-016 SHALL on write IRQ_CLR: pend<=0 for addressed channel; wdata ignored; reg 3 writes ignored.
REQ-017 SHALL generate tick when en=1 and pre_cnt==presc, then pre_cnt<=0; else pre_cnt+1 while en=1; tick period = presc+1 clk cycles.
REQ-018 SHALL hold count and pre_cnt (pre_cnt at 0 after CTRL write) while en=0.
REQ-019 Mode 0 one-shot: on tick, count!=0 -> count-1; transition 1->0 sets pend and out<=1 (level); at 0 count stays 0, no further events.
REQ-020 Mode 1 periodic: on tick, count==0 -> count<=load, out pulses high exactly one cycle, pend set; else count-1; period = (load+1) ticks; load=0 gives event every tick.
REQ-021 Mode 2 square wave: reload rule as REQ-020 but out toggles on each reload instead of pulsing; pend set on each reload.
REQ-022 Mode 3 free-run up: on tick count+1 mod 2^CNT_W; wrap to 0 sets pend, out pulses one cycle; load used only by LOAD write.
REQ-023 SHALL give write priority: write to a channel in same cycle as its tick applies the write; that tick is discarded.
REQ-024 SHALL give set priority: pend set event and IRQ_CLR in same cycle leaves pend=1.
REQ-025 SHALL operate channels independently; a write affects only the addressed channel.
REQ-026 SHALL register rd_data: rd_data(t+1) = count(t) of channel addressed at t; latency 1 cycle, independent of we.
REQ-027 SHALL treat channel index >= CH_NUM as no-op on write and return 0 on read.
REQ-028 irq SHALL be combinational from registered pend and irq_en, no extra latency.

Reset
REQ-029 SHALL, while RSTN=0 at a clk edge, clear all load, count, pre_cnt, en, mode, irq_en, presc, pend, out and rd_data to 0; irq=0.
REQ-030 SHALL abort any in-progress count on reset mid-operation; no event emitted in the reset cycle; writes during reset ignored.

Verification
REQ-031 Ch0 LOAD=5, CTRL en=1 mode=0 presc=0 -> count 5,4,..,0 over 5 cycles; ch_out[0] rises with count 0 and stays; pend[0]=1; no further change.
REQ-032 Ch1 LOAD=3, CTRL en=1 mode=1 presc=2 irq_en=1 -> ch_out[1] one-cycle pulse every 12 clk; irq=1 after first; IRQ_CLR drops pend[1] next cycle.
REQ-033 Ch2 mode=2 LOAD=0 presc=0 -> ch_out[2] toggles every cycle; ch3 mode=3 CNT_W=8 build, LOAD=0xFE -> wrap after 2 ticks, pulse, pend[3]=1.
REQ-034 LOAD write to ch1 coinciding with its tick -> count equals written value, no reload event; IRQ_CLR coinciding with set -> pend stays 1.
REQ-035 en=0 mid-count (count=7) -> count holds 7 for 20 cycles; rd_data shows 7 one cycle after addr selects channel; en=1 resumes from 7.
REQ-036 RSTN low one cycle while ch0 counting -> next cycle all outputs 0, count 0, en 0; writes during reset cycle have no effect.
